// File: rtl/dfc_pkg.sv
// -----------------------------------------------------------------------------
// dfc_pkg
// Shared definitions for the delayed-flow-control sender/receiver pair.
//   STATS_W   : width of the optional traffic statistics counters.
//   delay_ok  : round-trip budget check. The receiver's skid depth is sized
//               for 'delay' cycles of overshoot. The sender must not add more
//               latency than that between the receiver dropping its ready bit
//               and the last in-flight word landing.
// -----------------------------------------------------------------------------
package dfc_pkg;

  localparam int unsigned STATS_W = 32;

  function automatic bit delay_ok(input int unsigned pstages,
                                  input int unsigned rstages,
                                  input int unsigned delay);
    return (pstages + rstages) <= delay;
  endfunction

  function automatic bit stages_ok(input int unsigned pstages,
                                   input int unsigned rstages);
    return (pstages >= 1) && (rstages >= 1);
  endfunction

endpackage

// File: rtl/dfc_pipe.sv
// -----------------------------------------------------------------------------
// dfc_pipe
// Valid+data shift chain with synchronous active-high reset and no stall path.
// Stage 1 is a launch register: its valid bit follows in_valid every cycle, and
// its data register only captures in_data when in_valid is set. This keeps the
// data bus quiet during bubbles. Later stages copy valid and data from the
// previous stage unconditionally.
//
// Parameters:
//   width : data width in bits (>=1)
//   depth : number of stages (>=1)
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   in_valid   : word present at the chain input this cycle
//   in_data    : word to launch
//   out_valid  : valid bit of the last stage
//   out_data   : data of the last stage
//   valids     : valid bits of every stage, bit 0 = stage 1
// -----------------------------------------------------------------------------
module dfc_pipe #(
  parameter int width = 8,
  parameter int depth = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [width-1:0] in_data,
  output logic             out_valid,
  output logic [width-1:0] out_data,
  output logic [depth-1:0] valids
);

  logic [depth-1:0] v;
  logic [width-1:0] d [depth];

  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      for (int i = 0; i < depth; i++) begin
        d[i] <= '0;
      end
    end else begin
      v[0] <= in_valid;
      if (in_valid) begin
        d[0] <= in_data;
      end
      for (int i = 1; i < depth; i++) begin
        v[i] <= v[i-1];
        d[i] <= d[i-1];
      end
    end
  end

  assign out_valid = v[depth-1];
  assign out_data  = d[depth-1];
  assign valids    = v;

endmodule

// File: rtl/dfc_sender.sv
// -----------------------------------------------------------------------------
// dfc_sender
// Transmit side of the delayed-flow-control link. Accepts words from an
// internal srdy/drdy producer and launches them onto a long registered link.
// The receiver's ready bit (p_drdy) is a threshold flag. It is retimed here, so
// the sender may keep launching for rstages cycles after the receiver drops it.
// Those words, plus the ones already in the output pipeline, land in the
// receiver's skid buffer. Once a word is launched it is never held back.
//
// Parameters:
//   width   : datapath width
//   pstages : output pipeline stages on p_srdy/p_data (stage 1 = launch reg)
//   rstages : retiming flops on p_drdy
//   delay   : round-trip budget of the receiver; pstages+rstages must fit
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   c_srdy       : producer word valid
//   c_drdy       : accept (registered, straight from the retiming chain)
//   c_data       : producer word
//   p_srdy       : link valid from the last pipeline stage
//   p_drdy       : link flow control from the receiver, 1 = may send
//   p_data       : link data from the last pipeline stage
//   p_idle       : no valid word anywhere in the output pipeline
//   tx_count     : (DFC_SENDER_STATS_EN) c-side transfers, wraps
//   stall_count  : (DFC_SENDER_STATS_EN) cycles with c_srdy & ~c_drdy, wraps
//
// Build option: define DFC_SENDER_STATS_EN to add the two statistics counters.
// They only observe c-side handshakes, so datapath timing is the same either way.
// -----------------------------------------------------------------------------
module dfc_sender
  import dfc_pkg::*;
#(
  parameter int width   = 8,
  parameter int pstages = 1,
  parameter int rstages = 1,
  parameter int delay   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               c_srdy,
  output logic               c_drdy,
  input  logic [width-1:0]   c_data,
  output logic               p_srdy,
  input  logic               p_drdy,
  output logic [width-1:0]   p_data,
  output logic               p_idle
`ifdef DFC_SENDER_STATS_EN
  ,
  output logic [STATS_W-1:0] tx_count,
  output logic [STATS_W-1:0] stall_count
`endif
);

  if (!stages_ok(pstages, rstages)) begin : g_bad_stages
    $error("dfc_sender: pstages and rstages must both be at least 1");
  end

  if (!delay_ok(pstages, rstages, delay)) begin : g_bad_budget
    $error("dfc_sender: pstages + rstages exceeds the receiver delay budget");
  end

  logic [rstages-1:0] rchain;
  logic               launch;
  logic [pstages-1:0] stage_valids;

  // The chain resets to 0, so nothing is accepted until the receiver's ready
  // has made it all the way through after reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      rchain <= '0;
    end else begin
      rchain[0] <= p_drdy;
      for (int i = 1; i < rstages; i++) begin
        rchain[i] <= rchain[i-1];
      end
    end
  end

  assign c_drdy = rchain[rstages-1];
  assign launch = c_srdy & c_drdy;

  dfc_pipe #(
    .width (width),
    .depth (pstages)
  ) u_out_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (launch),
    .in_data   (c_data),
    .out_valid (p_srdy),
    .out_data  (p_data),
    .valids    (stage_valids)
  );

  assign p_idle = ~|stage_valids;

`ifdef DFC_SENDER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_count    <= '0;
      stall_count <= '0;
    end else begin
      if (launch) begin
        tx_count <= tx_count + STATS_W'(1);
      end
      if (c_srdy & ~c_drdy) begin
        stall_count <= stall_count + STATS_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dfc_sender.sv
// -----------------------------------------------------------------------------
// tb_dfc_sender
// Two senders side by side: A with default parameters (pstages=1, rstages=1)
// and B with pstages=3, rstages=2, delay=5. Each instance has its own producer.
// A producer advances to its next word only after a transfer. A reference
// model schedules every transfer to appear pstages cycles later. It derives
// c_drdy from the p_drdy/reset history. Each cycle it checks c_drdy, p_srdy,
// p_data and p_idle. Directed sections add explicit hand-computed checks.
// -----------------------------------------------------------------------------
module tb_dfc_sender;

  localparam int HIST = 4096;
  localparam int PST [2] = '{1, 3};
  localparam int RST [2] = '{1, 2};

  logic clk = 1'b0;
  logic reset;

  logic       srdy_a, drdy_a, psrdy_a, pdrdy_a, idle_a;
  logic [7:0] cdata_a, pdata_a;
  logic       srdy_b, drdy_b, psrdy_b, pdrdy_b, idle_b;
  logic [7:0] cdata_b, pdata_b;
  int         word_a, word_b;

`ifdef DFC_SENDER_STATS_EN
  logic [31:0] tx_a, stall_a, tx_b, stall_b;
  logic [31:0] exp_tx [2];
  logic [31:0] exp_stall [2];
`endif

  always #5 clk = ~clk;

  always_comb cdata_a = word_a[7:0];
  always_comb cdata_b = word_b[7:0];

  dfc_sender u_dut_a (
    .clk    (clk),
    .reset  (reset),
    .c_srdy (srdy_a),
    .c_drdy (drdy_a),
    .c_data (cdata_a),
    .p_srdy (psrdy_a),
    .p_drdy (pdrdy_a),
    .p_data (pdata_a),
    .p_idle (idle_a)
`ifdef DFC_SENDER_STATS_EN
    ,
    .tx_count    (tx_a),
    .stall_count (stall_a)
`endif
  );

  dfc_sender #(
    .width   (8),
    .pstages (3),
    .rstages (2),
    .delay   (5)
  ) u_dut_b (
    .clk    (clk),
    .reset  (reset),
    .c_srdy (srdy_b),
    .c_drdy (drdy_b),
    .c_data (cdata_b),
    .p_srdy (psrdy_b),
    .p_drdy (pdrdy_b),
    .p_data (pdata_b),
    .p_idle (idle_b)
`ifdef DFC_SENDER_STATS_EN
    ,
    .tx_count    (tx_b),
    .stall_count (stall_b)
`endif
  );

  typedef struct {
    logic [7:0] data;
    int         due;
  } flight_t;

  flight_t q_a [$];
  flight_t q_b [$];
  bit      pd_hist [2][HIST];
  bit      rst_hist [HIST];
  int      edge_n;
  int      n_checks;
  int      n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h (edge %0d)", tag, got, want, edge_n);
    end
  endtask

  // After edge n, c_drdy shows the p_drdy value sampled rstages-1 edges
  // earlier, unless a reset was sampled anywhere in that window.
  function automatic bit exp_drdy(input int i);
    int k;
    k = edge_n - RST[i] + 1;
    if (k < 1) return 1'b0;
    for (int e = k; e <= edge_n; e++) begin
      if (rst_hist[e]) return 1'b0;
    end
    return pd_hist[i][k];
  endfunction

  task automatic check_dut(input int i, input string nm, input logic drdy, input logic psrdy,
                           input logic [7:0] pdata, input logic idle);
    flight_t head;
    bit      have;
    bit      exp_v;
    have = 1'b0;
    head.data = '0;
    head.due = 0;
    if (i == 0) begin
      if (q_a.size() > 0) begin have = 1'b1; head = q_a[0]; end
    end else begin
      if (q_b.size() > 0) begin have = 1'b1; head = q_b[0]; end
    end
    check({nm, ".c_drdy"}, drdy, exp_drdy(i));
    check({nm, ".p_idle"}, idle, !have);
    exp_v = have && (head.due == edge_n);
    check({nm, ".p_srdy"}, psrdy, exp_v);
    if (exp_v) begin
      check({nm, ".p_data"}, pdata, head.data);
      if (i == 0) void'(q_a.pop_front());
      else        void'(q_b.pop_front());
    end
  endtask

  task automatic step();
    bit         rst_s;
    bit         srdy_s [2];
    bit         drdy_s [2];
    bit         pd_s [2];
    logic [7:0] data_s [2];
    flight_t    f;
    rst_s     = reset;
    srdy_s[0] = srdy_a;  drdy_s[0] = drdy_a;  pd_s[0] = pdrdy_a;  data_s[0] = cdata_a;
    srdy_s[1] = srdy_b;  drdy_s[1] = drdy_b;  pd_s[1] = pdrdy_b;  data_s[1] = cdata_b;
    @(posedge clk);
    #1;
    edge_n++;
    if (edge_n >= HIST) begin
      $display("FAIL step_budget: edge %0d, limit %0d", edge_n, HIST - 1);
      $fatal(1, "history exhausted");
    end
    rst_hist[edge_n] = rst_s;
    for (int i = 0; i < 2; i++) begin
      pd_hist[i][edge_n] = pd_s[i];
`ifdef DFC_SENDER_STATS_EN
      if (rst_s) begin
        exp_tx[i]    = '0;
        exp_stall[i] = '0;
      end else begin
        if (srdy_s[i] && drdy_s[i])  exp_tx[i]    = exp_tx[i] + 1;
        if (srdy_s[i] && !drdy_s[i]) exp_stall[i] = exp_stall[i] + 1;
      end
`endif
      if (rst_s) begin
        if (i == 0) q_a.delete();
        else        q_b.delete();
      end else if (srdy_s[i] && drdy_s[i]) begin
        f.data = data_s[i];
        f.due  = edge_n + PST[i] - 1;
        if (i == 0) begin q_a.push_back(f); word_a++; end
        else        begin q_b.push_back(f); word_b++; end
      end
    end
    check_dut(0, "a", drdy_a, psrdy_a, pdata_a, idle_a);
    check_dut(1, "b", drdy_b, psrdy_b, pdata_b, idle_b);
`ifdef DFC_SENDER_STATS_EN
    check("a.tx_count", tx_a, exp_tx[0]);
    check("a.stall_count", stall_a, exp_stall[0]);
    check("b.tx_count", tx_b, exp_tx[1]);
    check("b.stall_count", stall_b, exp_stall[1]);
`endif
  endtask

  initial begin
    int   arrivals;
    logic pd_m1, pd_m2;

    n_checks = 0;
    n_errors = 0;
    edge_n   = 0;
    reset    = 1'b1;
    srdy_a = 1'b0; pdrdy_a = 1'b1; word_a = 0;
    srdy_b = 1'b0; pdrdy_b = 1'b1; word_b = 8'h80;
`ifdef DFC_SENDER_STATS_EN
    exp_tx    = '{32'd0, 32'd0};
    exp_stall = '{32'd0, 32'd0};
`endif

    // Reset state.
    repeat (3) step();
    check("rst.a.c_drdy", drdy_a, 1'b0);
    check("rst.a.p_srdy", psrdy_a, 1'b0);
    check("rst.a.p_idle", idle_a, 1'b1);
    check("rst.a.p_data", pdata_a, 8'h00);
    check("rst.b.c_drdy", drdy_b, 1'b0);
    check("rst.b.p_srdy", psrdy_b, 1'b0);
    check("rst.b.p_idle", idle_b, 1'b1);
    check("rst.b.p_data", pdata_b, 8'h00);

    // Stream 0x01..0x10 into A from reset release (cycle 0).
    reset  = 1'b0;
    word_a = 1;
    srdy_a = 1'b1;
    step();
    check("t1.c_drdy@1", drdy_a, 1'b1);
    check("t1.p_srdy@1", psrdy_a, 1'b0);
    for (int c = 2; c <= 17; c++) begin
      step();
      if (word_a > 16) srdy_a = 1'b0;
      check($sformatf("t1.p_srdy@%0d", c), psrdy_a, 1'b1);
      check($sformatf("t1.p_data@%0d", c), pdata_a, 32'(c - 1));
      check($sformatf("t1.p_idle@%0d", c), idle_a, 1'b0);
    end
    step();
    check("t1.p_idle_end", idle_a, 1'b1);

    // B streams, then p_drdy drops at cycle T. Words fired at edges
    // T-1..T+2 are still due at T+1..T+4, so four more arrive.
    srdy_b = 1'b1;
    repeat (8) step();
    pdrdy_b  = 1'b0;
    arrivals = 0;
    step(); if (psrdy_b) arrivals++;
    check("t2.c_drdy@T+1", drdy_b, 1'b1);
    step(); if (psrdy_b) arrivals++;
    check("t2.c_drdy@T+2", drdy_b, 1'b0);
    step(); if (psrdy_b) arrivals++;
    step(); if (psrdy_b) arrivals++;
    check("t2.p_idle@T+4", idle_b, 1'b0);
    step(); if (psrdy_b) arrivals++;
    check("t2.p_idle@T+5", idle_b, 1'b1);
    check("t2.arrivals", arrivals, 32'd4);
    srdy_b  = 1'b0;
    pdrdy_b = 1'b1;
    repeat (3) step();

    // p_drdy toggling every cycle on both senders.
    srdy_a = 1'b1;
    srdy_b = 1'b1;
    pd_m1  = 1'b1;
    pd_m2  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      pdrdy_a = (c % 2 == 0);
      pdrdy_b = (c % 2 == 0);
      pd_m2   = pd_m1;
      pd_m1   = pdrdy_b;
      step();
      check($sformatf("t3.a.c_drdy[%0d]", c), drdy_a, pdrdy_a);
      check($sformatf("t3.b.c_drdy[%0d]", c), drdy_b, pd_m2);
    end
    srdy_a = 1'b0; pdrdy_a = 1'b1;
    srdy_b = 1'b0; pdrdy_b = 1'b1;
    repeat (6) step();

    // Reset for one cycle with three words in B's pipeline.
    srdy_b = 1'b1;
    repeat (5) step();
    check("t4.b.in_flight", idle_b, 1'b0);
    srdy_b = 1'b0;
    reset  = 1'b1;
    step();
    check("t4.b.p_srdy", psrdy_b, 1'b0);
    check("t4.b.p_idle", idle_b, 1'b1);
    reset    = 1'b0;
    arrivals = 0;
    repeat (8) begin
      step();
      if (psrdy_b) arrivals++;
    end
    check("t4.b.dropped", arrivals, 32'd0);

    // Random handshakes on both senders; the model checks order and timing.
    for (int c = 0; c < 1500; c++) begin
      srdy_a  = 1'($urandom_range(0, 1));
      pdrdy_a = 1'($urandom_range(0, 1));
      srdy_b  = 1'($urandom_range(0, 1));
      pdrdy_b = 1'($urandom_range(0, 1));
      step();
    end
    srdy_a = 1'b0; pdrdy_a = 1'b1;
    srdy_b = 1'b0; pdrdy_b = 1'b1;
    repeat (8) step();
    check("t5.a.drained", idle_a, 1'b1);
    check("t5.b.drained", idle_b, 1'b1);

    // Statistics: 37 stall cycles, then 100 transfers.
    pdrdy_a = 1'b0; pdrdy_b = 1'b0;
    reset = 1'b1;
    step();
    reset  = 1'b0;
    srdy_a = 1'b1; srdy_b = 1'b1;
    repeat (37) step();
    srdy_a = 1'b0; srdy_b = 1'b0;
    pdrdy_a = 1'b1; pdrdy_b = 1'b1;
    repeat (3) step();
    srdy_a = 1'b1; srdy_b = 1'b1;
    repeat (100) step();
    srdy_a = 1'b0; srdy_b = 1'b0;
    repeat (4) step();
`ifdef DFC_SENDER_STATS_EN
    check("t6.a.tx_count", tx_a, 32'd100);
    check("t6.a.stall_count", stall_a, 32'd37);
    check("t6.b.tx_count", tx_b, 32'd100);
    check("t6.b.stall_count", stall_b, 32'd37);
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
`ifdef DFC_SENDER_STATS_EN
    check("t6.a.tx_clear", tx_a, 32'd0);
    check("t6.a.stall_clear", stall_a, 32'd0);
    check("t6.b.tx_clear", tx_b, 32'd0);
    check("t6.b.stall_clear", stall_b, 32'd0);
`endif
    check("t6.a.p_idle", idle_a, 1'b1);
    check("t6.b.p_idle", idle_b, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
